// File: rtl/systolic_result_drain_pkg.sv
// Shared types, widths and lane arithmetic for the systolic result drain.
package systolic_result_drain_pkg;

   localparam int unsigned N_DEF          = 4;
   localparam int unsigned A_W_DEF        = 32;
   localparam int unsigned ROWS_DEF       = 4;
   localparam int unsigned FIFO_DEPTH_DEF = 4;

   localparam int unsigned ROW_IDX_W = $clog2(ROWS_DEF);
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH_DEF + 1);
   localparam int unsigned ROW_W     = N_DEF * A_W_DEF;

   typedef logic [A_W_DEF-1:0] lane_t;
   typedef logic [ROW_W-1:0]   row_vec_t;

   typedef struct packed {
      logic [ROW_IDX_W-1:0] row;
      row_vec_t             data;
   } result_t;

   function automatic lane_t lane_get(input row_vec_t vec, input int unsigned j);
      return vec[j*A_W_DEF +: A_W_DEF];
   endfunction

   // Two's-complement add; the carry out of the top bit is discarded so results wrap.
   function automatic lane_t lane_add(input lane_t a, input lane_t b);
      return a + b;
   endfunction

endpackage

// File: rtl/systolic_result_drain_sync_fifo.sv
// Circular-buffer FIFO with a registered head that only moves on pop or push-into-empty.
module systolic_result_drain_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             push_i,
   input  logic [WIDTH-1:0]                 push_data_i,
   input  logic                             pop_ready_i,
   output logic                             valid_o,
   output logic [WIDTH-1:0]                 data_o,
   output logic [$clog2(DEPTH+1)-1:0]       count_o,
   output logic                             drop_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [PW-1:0]    rd_ptr_d, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q;
   logic             pop, full, push_acc;

   assign pop      = (count_q != '0) && pop_ready_i;
   assign full     = (count_q == CW'(DEPTH));
   assign push_acc = push_i && (!full || pop);
   assign drop_o   = push_i && full && !pop;

   assign rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
   assign wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;

   always_comb begin
      count_d = count_q;
      case ({push_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push_acc) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         if (push_acc) wr_ptr_q <= wr_ptr_d;
         if (pop)      rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         // Head tracks the next stored entry; when the FIFO drains it keeps the last value shown.
         if (pop && (count_q > CW'(1))) begin
            head_q <= mem_q[rd_ptr_d];
         end else if (push_acc && ((count_q == '0) || (pop && (count_q == CW'(1))))) begin
            head_q <= push_data_i;
         end
      end
   end

   assign valid_o = (count_q != '0);
   assign data_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/systolic_result_drain.sv
// Accumulates deskewed rows across K-tiles and queues finished rows for the consumer.
module systolic_result_drain
   import systolic_result_drain_pkg::*;
#(
   parameter int unsigned N          = N_DEF,
   parameter int unsigned A_W        = A_W_DEF,
   parameter int unsigned ROWS       = ROWS_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic                               in_valid_i,
   input  logic [N*A_W-1:0]                   sum_in_i,
   input  logic                               in_first_i,
   input  logic                               in_last_i,
   output logic                               out_valid_o,
   output logic [N*A_W-1:0]                   out_data_o,
   output logic [$clog2(ROWS)-1:0]            out_row_o,
   input  logic                               out_ready_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o,
   output logic                               overflow_o
);

   logic [ROW_IDX_W-1:0] row_ptr_q, row_ptr_d;
   row_vec_t             acc_q [ROWS];
   row_vec_t             new_row;
   result_t              push_res, head_res;
   logic                 push, drop;
   logic                 overflow_q, overflow_d;

   always_comb begin
      new_row = '0;
      for (int unsigned j = 0; j < N; j++) begin
         new_row[j*A_W +: A_W] = in_first_i
            ? lane_get(sum_in_i, j)
            : lane_add(lane_get(acc_q[row_ptr_q], j), lane_get(sum_in_i, j));
      end
   end

   assign row_ptr_d  = (row_ptr_q == ROW_IDX_W'(ROWS-1)) ? '0 : row_ptr_q + 1'b1;
   assign push       = in_valid_i && in_last_i;
   assign overflow_d = overflow_q || drop;

   always_comb begin
      push_res      = '0;
      push_res.row  = row_ptr_q;
      push_res.data = new_row;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         row_ptr_q  <= '0;
         overflow_q <= 1'b0;
         for (int unsigned r = 0; r < ROWS; r++) begin
            acc_q[r] <= '0;
         end
      end else begin
         overflow_q <= overflow_d;
         if (in_valid_i) begin
            acc_q[row_ptr_q] <= new_row;
            row_ptr_q        <= row_ptr_d;
         end
      end
   end

   systolic_result_drain_sync_fifo #(
      .WIDTH ($bits(result_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .push_i      (push),
      .push_data_i (push_res),
      .pop_ready_i (out_ready_i),
      .valid_o     (out_valid_o),
      .data_o      (head_res),
      .count_o     (fifo_count_o),
      .drop_o      (drop)
   );

   assign out_data_o = head_res.data;
   assign out_row_o  = head_res.row;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: a per-row accumulator model feeds an expected-result queue.
module tb_systolic_result_drain;

   localparam int N     = 4;
   localparam int A_W   = 32;
   localparam int ROWS  = 4;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid, in_first, in_last, out_ready;
   logic [127:0]   sum_in;
   logic           out_valid, overflow;
   logic [127:0]   out_data;
   logic [1:0]     out_row;
   logic [2:0]     fifo_count;

   always #5 clk = ~clk;

   systolic_result_drain #(
      .N(N), .A_W(A_W), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .in_valid_i   (in_valid),
      .sum_in_i     (sum_in),
      .in_first_i   (in_first),
      .in_last_i    (in_last),
      .out_valid_o  (out_valid),
      .out_data_o   (out_data),
      .out_row_o    (out_row),
      .out_ready_i  (out_ready),
      .fifo_count_o (fifo_count),
      .overflow_o   (overflow)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [129:0] sb[$];
   logic [31:0]  macc [ROWS][N];
   int           mrow;
   bit           movf;
   logic [129:0] last_head;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
      return {d, c, b, a};
   endfunction

   task automatic model_reset();
      sb.delete();
      for (int r = 0; r < ROWS; r++)
         for (int j = 0; j < N; j++)
            macc[r][j] = '0;
      mrow      = 0;
      movf      = 1'b0;
      last_head = '0;
   endtask

   // Called at a falling edge: drive one beat, check the head, update the model, advance one clock.
   task automatic cycle(input bit v, input bit f, input bit l, input logic [127:0] sum, input bit rdy);
      logic [129:0] e;
      logic [127:0] nr;
      logic [1:0]   rr;
      in_valid  = v;
      in_first  = f;
      in_last   = l;
      sum_in    = sum;
      out_ready = rdy;
      #1;
      check("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
         e = sb[0];
         check("out_row", out_row, e[129:128]);
         check("out_data", out_data, e[127:0]);
         if (rdy) begin
            void'(sb.pop_front());
            last_head = e;
         end
      end else begin
         check("hold_row", out_row, last_head[129:128]);
         check("hold_data", out_data, last_head[127:0]);
      end
      if (v) begin
         nr = '0;
         for (int j = 0; j < N; j++) begin
            nr[j*32 +: 32] = f ? sum[j*32 +: 32] : macc[mrow][j] + sum[j*32 +: 32];
            macc[mrow][j]  = nr[j*32 +: 32];
         end
         if (l) begin
            rr = mrow[1:0];
            if (sb.size() < DEPTH) sb.push_back({rr, nr});
            else movf = 1'b1;
         end
         mrow = (mrow + 1) % ROWS;
      end
      @(posedge clk);
      @(negedge clk);
      check("fifo_count", fifo_count, sb.size());
      check("overflow", overflow, movf);
   endtask

   task automatic drain();
      for (int k = 0; k < DEPTH + 2; k++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      sum_in    = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", out_valid, 1'b0);
      check("rst_count", fifo_count, 3'd0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_data", out_data, 128'd0);
      check("rst_row", out_row, 2'd0);
      reset = 1'b0;
      @(negedge clk);

      // single tile, raw values straight through
      for (int r = 0; r < 4; r++) cycle(1'b1, 1'b1, 1'b1, mk(r+1, r+2, r+3, r+4), 1'b1);
      drain();

      // three K-tiles: 10 + 5 - 3
      for (int t = 0; t < 3; t++)
         for (int r = 0; r < 4; r++)
            cycle(1'b1, t == 0, t == 2,
                  (t == 0) ? mk(10, 10, 10, 10) : (t == 1) ? mk(5, 5, 5, 5) : mk(-3, -3, -3, -3),
                  1'b1);
      drain();

      // overflow: five last beats with the consumer stalled
      for (int r = 0; r < 5; r++) cycle(1'b1, 1'b1, 1'b1, mk(100+r, 200+r, 300+r, 400+r), 1'b0);
      check("ovf_count", fifo_count, 3'd4);
      check("ovf_flag", overflow, 1'b1);
      drain();

      // lane wrap-around
      for (int r = 0; r < 4; r++) cycle(1'b1, 1'b1, 1'b0, mk(32'h7fffffff, 32'hffffffff, r, 0), 1'b1);
      for (int r = 0; r < 4; r++) cycle(1'b1, 1'b0, 1'b1, mk(1, 32'hffffffff, 0, r), 1'b0);
      check("wrap_lane0", out_data[31:0], 32'h80000000);
      check("wrap_lane1", out_data[63:32], 32'hfffffffe);
      drain();

      // reset in the middle of an accumulating tile
      for (int r = 0; r < 2; r++) cycle(1'b1, 1'b1, 1'b1, mk(7, 8, 9, r), 1'b0);
      for (int r = 0; r < 2; r++) cycle(1'b1, 1'b0, 1'b0, mk(1, 1, 1, 1), 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      model_reset();
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_count", fifo_count, 3'd0);
      check("mid_rst_ovf", overflow, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int r = 0; r < 4; r++) cycle(1'b1, 1'b1, 1'b1, mk(50+r, 60+r, 70+r, 80+r), 1'b1);
      drain();

      // full FIFO with a push and a pop on the same edge
      for (int r = 0; r < 4; r++) cycle(1'b1, 1'b1, 1'b1, mk(r, 2*r, 3*r, 4*r), 1'b0);
      cycle(1'b1, 1'b1, 1'b1, mk(11, 22, 33, 44), 1'b1);
      check("full_pop_count", fifo_count, 3'd4);
      check("full_pop_ovf", overflow, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Downstream stage of the systolic matrix-multiply top level. Consumes the deskewed per-column sum vector, one output row per cycle.
- Accumulates partial-product rows across successive K-tiles in a row-indexed accumulator buffer.
- On the final tile, pushes completed rows into an output FIFO with a valid/ready interface to the consumer.
- The array cannot stall, so FIFO overflow is detected and flagged, never back-pressured.

Parameters:
N, 4, number of result lanes (array columns)
A_W, 32, accumulator/lane width in bits
ROWS, 4, rows per tile (accumulator depth); must be >= 2
FIFO_DEPTH, 4, output FIFO entries; must be >= 2

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  sum_in carries a valid row this cycle
sum_in  input  N*A_W  deskewed row; lane j at [j*A_W +: A_W], signed
in_first  input  1  first K-tile: overwrite accumulator instead of adding
in_last  input  1  last K-tile: push the accumulated result to the FIFO
out_valid  output  1  FIFO head valid
out_data  output  N*A_W  FIFO head row, same lane packing as sum_in
out_row  output  $clog2(ROWS)  row index of the FIFO head
out_ready  input  1  consumer accepts the head
fifo_count  output  $clog2(FIFO_DEPTH+1)  current occupancy
overflow  output  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (async, active-high): row_ptr=0, all accumulator entries=0, FIFO empty, out_valid=0, out_data=0, out_row=0, fifo_count=0, overflow=0. A reset asserted mid-tile discards all partial state. After reset deasserts, the next valid beat is row 0.
- Accept beat: the rising edge with in_valid=1. Input is never stalled.
- Per-lane new value: new_j = in_first ? sum_in_j : acc[row_ptr]_j + sum_in_j. Signed two's-complement, truncated to A_W (wraps, no saturation). Lanes are independent.
- acc[row_ptr] <= new, written every accepted beat, including beats where in_last=1.
- row_ptr increments per accepted beat and wraps ROWS-1 -> 0. in_first and in_last are sampled per beat. Upstream holds them constant across a tile; the block does not check this.
- Push when an accepted beat has in_last=1: {row_ptr, new} enters the FIFO tail. Same-edge value, so total latency is 1 cycle to FIFO storage. out_valid rises on the edge after the push when the FIFO was empty.
- Pop: out_valid && out_ready at an edge removes the head. out_data/out_row change only on pop or push-into-empty.
- When empty: out_valid=0, and out_data/out_row hold their last value (0 after reset).
- Full-FIFO push without a same-cycle pop: the push is dropped, overflow <= 1 (sticky until reset), and the accumulator is still updated.
- Full-FIFO push with a same-cycle pop: both occur, fifo_count is unchanged, no overflow.
- Simultaneous push and pop at non-full occupancy: fifo_count is unchanged and ordering is preserved.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH. fifo_count is exact. There is no combinational path from in_valid to out_valid.
- Accumulator read is combinational from a register array indexed by row_ptr. No hazard, since consecutive beats address different rows (ROWS >= 2).

Decomposition:
- Shared package: lane-extraction helper, signed lane add function (A_W wrap), and the clog2-derived width localparams (ROW_IDX_W, CNT_W).
- One natural sub-module: sync_fifo (parameterised width/depth, valid/ready pop, push-with-pop-when-full allowed, count output), instantiated with width ROW_IDX_W+N*A_W.

Test Plan:
N=4, A_W=32, ROWS=4, FIFO_DEPTH=4.
1. Single tile: 4 beats, first=last=1, row r lanes {r+1, r+2, r+3, r+4}, out_ready=1 -> 4 outputs in order, out_row 0..3, data matching input; overflow=0.
2. Three tiles: first tile all lanes 10 (first=1), second tile 5, third tile -3 (last=1) -> outputs all lanes 12, only after the third tile, out_row 0..3.
3. Overflow: out_ready=0, then one tile of 5 rows (5 last beats; the 5th beat is row 0 again due to wrap) -> fifo_count=4, overflow=1 after the 5th beat, and the 5th result is dropped. Then out_ready=1 -> exactly 4 outputs with rows 0,1,2,3.
4. Wrap arithmetic: first tile lane0=0x7FFFFFFF, last tile lane0=1 -> lane0 output 0x80000000; lane1 -1 + -1 -> 0xFFFFFFFE.
5. Reset mid-tile: reset asserted after 2 beats of an accumulating tile -> immediately out_valid=0, fifo_count=0, overflow=0. A next tile with first=last=1 outputs its raw values starting at out_row=0.
6. Full plus simultaneous pop: FIFO full, out_ready=1 on the same edge as a last beat -> no overflow, fifo_count stays 4, output order preserved.
